nested_counter: RTL and testbench
=================================

NESTED_COUNTER -- requirements
Module: nested_counter

Interface
REQ-001 Parameter W, default 8: bit width of each level's count and max.
REQ-002 Parameter N, default 3: number of nested levels; level 0 is innermost (fastest).
REQ-003 Parameter STOP, default 0: 0 = wrap after final element; 1 = hold at final element and raise done.
REQ-004 clk  input  1  rising-edge clock, sole clock domain.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 load  input  1  synchronous capture of max_in and restart of all levels.
REQ-007 en  input  1  advance-one-element strobe.
REQ-008 max_in  input  N*W  per-level terminal value, level i in bits [i*W +: W].
REQ-009 count  output  N*W  per-level current count, level i in bits [i*W +: W].
REQ-010 last  output  N  combinational, level i at its final element including all inner levels.
REQ-011 last_clk  output  N  registered one-cycle pulse marking level i's wrap/terminal event.
REQ-012 done  output  1  sticky terminal flag, STOP=1 only; tied 0 when STOP=0.

Function
REQ-013 Internal max register max_q (N*W) shall capture max_in on any clock edge with load=1.
REQ-014 load=1 shall clear all count levels to 0, clear done and clear last_clk on the same edge.
REQ-015 load shall take priority over en in the same cycle; that en is discarded.
REQ-016 last[i] shall equal (count[i]==max_q[i]) AND last[i-1], with last[-1] taken as 1.
REQ-017 On en=1 (load=0, done=0), level 0 shall increment by 1, or wrap to 0 when count[0]==max_q[0].
REQ-018 On the same en, level i>0 shall change only when last[i-1]=1: increment, or wrap to 0 when count[i]==max_q[i].
REQ-019 Levels with last[i-1]=0 shall hold their value.
REQ-020 last_clk[i] shall be 1 in the cycle after an accepted en with last[i]=1, and 0 otherwise.
REQ-021 All-levels wrap (STOP=0): en with last[N-1]=1 shall return every level to 0 in one edge.
REQ-022 STOP=1: en with last[N-1]=1 shall leave counts unchanged, set done, and pulse last_clk per REQ-020.
REQ-023 STOP=1: while done=1, en shall be ignored (counts, last_clk frozen at 0) until load or reset.
REQ-024 max_q[i]=0 shall make level i a single-element level: count[i] stays 0 and last[i] reduces to last[i-1].
REQ-025 Counts never exceed max_q, so no carry beyond W bits shall exist; arithmetic is W bits per level.
REQ-026 Total elements per pass shall be the product over i of (max_q[i]+1).
REQ-027 en=0 shall hold all state; last shall still reflect current count and max_q.
REQ-028 Changing max_in without load shall have no effect.

Reset
REQ-029 reset=1 shall asynchronously force count=0, max_q=0, last_clk=0 and done=0, independent of clk.
REQ-030 With max_q=0 after reset, last shall be all ones until a load.
REQ-031 Reset deassertion mid-pass shall resume from the cleared state at the next clock edge; no partial state is kept.
REQ-032 Reset asserted during a load or en cycle shall override both.

Verification
REQ-033 N=2, max_in={2,3} (level1=2, level0=3), load, 12 consecutive en -> count walks (0,0)..(2,3); last[1]=1 only at (2,3); last_clk[0] pulses after every 4th en; last_clk[1] pulses once after the 12th en; count returns to (0,0).
REQ-034 STOP=1, same maxima, 15 en -> counts freeze at (2,3) after the 12th en; done=1 from that edge; ensuing en produce no last_clk; load clears done and counts.
REQ-035 max_in level0=0, level1=4, load, 5 en -> count[0] stays 0; count[1] goes 0..4 then wraps; last[0]=1 throughout.
REQ-036 load and en high together at count (1,2) -> counts become (0,0); the en is not applied; new max_q is active next cycle.
REQ-037 Random en (20% duty), random maxima 0..20, repeated reload -> a scoreboard model matches count, last and last_clk every cycle.
REQ-038 reset pulse of 3 ns between clock edges mid-pass -> count=0 and last_clk=0 immediately, before the next edge.

Source files
------------

// File: rtl/nested_counter.sv
// N-level nested (odometer) counter with per-level terminal values captured on load.
// Counts advance one element per en; last is combinational, last_clk/done are registered one edge later; no backpressure.
module nested_counter #(
  parameter int W    = 8,
  parameter int N    = 3,
  parameter int STOP = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           en,
  input  logic [N*W-1:0] max_in,
  output logic [N*W-1:0] count,
  output logic [N-1:0]   last,
  output logic [N-1:0]   last_clk,
  output logic           done
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [N*W-1:0] max_q, max_d;
  logic [N*W-1:0] count_q, count_d;
  logic [N-1:0]   last_clk_q, last_clk_d;
  logic           done_q, done_d;

  // A level is at its final element only when every inner level is as well.
  always_comb begin
    logic carry;
    carry = 1'b1;
    for (int i = 0; i < N; i++) begin
      last[i] = (count_q[i*W +: W] == max_q[i*W +: W]) && carry;
      carry   = last[i];
    end
  end

  always_comb begin
    logic advance;
    max_d      = max_q;
    count_d    = count_q;
    last_clk_d = '0;
    done_d     = done_q;
    advance    = 1'b1;
    if (load) begin
      max_d   = max_in;
      count_d = '0;
      done_d  = 1'b0;
    end else if (en && !done_q) begin
      last_clk_d = last;
      if ((STOP != 0) && last[N-1]) begin
        // Terminal element in stop mode: hold the counts, only flag completion.
        done_d = 1'b1;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (advance) begin
            if (count_q[i*W +: W] == max_q[i*W +: W])
              count_d[i*W +: W] = '0;
            else
              count_d[i*W +: W] = count_q[i*W +: W] + ONE;
          end
          advance = last[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      max_q      <= '0;
      count_q    <= '0;
      last_clk_q <= '0;
      done_q     <= 1'b0;
    end else begin
      max_q      <= max_d;
      count_q    <= count_d;
      last_clk_q <= last_clk_d;
      done_q     <= done_d;
    end
  end

  assign count    = count_q;
  assign last_clk = last_clk_q;
  assign done     = (STOP != 0) ? done_q : 1'b0;

endmodule

// File: tb/tb_nested_counter.sv
// Bench for nested_counter: wrap and stop variants side by side against a linear-index reference model.
module tb_nested_counter;
  localparam int W = 8;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           reset, load, en;
  logic [N*W-1:0] max_in;
  logic [N*W-1:0] count0, count1;
  logic [N-1:0]   last0, last1, lc0, lc1;
  logic           done0, done1;

  int errs   = 0;
  int checks = 0;

  // Reference: each pass is a linear element index; per-level counts are its mixed-radix digits.
  int       m_max [2][2];
  int       m_idx [2];
  bit       m_done[2];
  logic [1:0] m_lc[2];

  always #5 clk = ~clk;

  nested_counter #(.W(W), .N(N), .STOP(0)) u_wrap (
    .clk(clk), .reset(reset), .load(load), .en(en), .max_in(max_in),
    .count(count0), .last(last0), .last_clk(lc0), .done(done0)
  );

  nested_counter #(.W(W), .N(N), .STOP(1)) u_stop (
    .clk(clk), .reset(reset), .load(load), .en(en), .max_in(max_in),
    .count(count1), .last(last1), .last_clk(lc1), .done(done1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int m_total(int s);
    return (m_max[s][0] + 1) * (m_max[s][1] + 1);
  endfunction

  function automatic logic [1:0] m_last(int s);
    int r0;
    r0 = m_max[s][0] + 1;
    return {((m_idx[s] + 1) % m_total(s)) == 0, ((m_idx[s] + 1) % r0) == 0};
  endfunction

  function automatic logic [15:0] m_count(int s);
    int r0, r1;
    r0 = m_max[s][0] + 1;
    r1 = m_max[s][1] + 1;
    return {8'((m_idx[s] / r0) % r1), 8'(m_idx[s] % r0)};
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_max[s][0] = 0;
      m_max[s][1] = 0;
      m_idx[s]    = 0;
      m_done[s]   = 1'b0;
      m_lc[s]     = 2'b00;
    end
  endtask

  task automatic model_step(input logic l, input logic e, input logic [15:0] mx);
    for (int s = 0; s < 2; s++) begin
      if (l) begin
        m_max[s][0] = int'(mx[7:0]);
        m_max[s][1] = int'(mx[15:8]);
        m_idx[s]    = 0;
        m_done[s]   = 1'b0;
        m_lc[s]     = 2'b00;
      end else if (e && !m_done[s]) begin
        m_lc[s] = m_last(s);
        if (m_idx[s] == m_total(s) - 1) begin
          if (s == 1) m_done[s] = 1'b1;
          else        m_idx[s]  = 0;
        end else begin
          m_idx[s]++;
        end
      end else begin
        m_lc[s] = 2'b00;
      end
    end
  endtask

  task automatic check_all();
    check_eq("wrap_count", 32'(count0), 32'(m_count(0)));
    check_eq("wrap_last",  32'(last0),  32'(m_last(0)));
    check_eq("wrap_lclk",  32'(lc0),    32'(m_lc[0]));
    check_eq("wrap_done",  32'(done0),  32'(m_done[0]));
    check_eq("stop_count", 32'(count1), 32'(m_count(1)));
    check_eq("stop_last",  32'(last1),  32'(m_last(1)));
    check_eq("stop_lclk",  32'(lc1),    32'(m_lc[1]));
    check_eq("stop_done",  32'(done1),  32'(m_done[1]));
  endtask

  task automatic cycle(input logic l, input logic e, input logic [15:0] mx);
    load   = l;
    en     = e;
    max_in = mx;
    model_step(l, e, mx);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    reset  = 1'b1;
    load   = 1'b0;
    en     = 1'b0;
    max_in = '0;
    model_reset();
    #12;
    check_all();
    check_eq("reset_last_ones", 32'(last0), 32'h3);
    reset = 1'b0;

    // Maxima {2,3}: 12 elements per pass; stop variant freezes on the last one.
    cycle(1'b1, 1'b0, {8'd2, 8'd3});
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b0, 1'b1, 16'($urandom));
      if (k % 4 != 0) check_eq("lclk0_between", 32'(lc0), 32'h0);
      if (k == 4)     check_eq("lclk0_4th",     32'(lc0), 32'h1);
    end
    check_eq("wrap_back_to_zero", 32'(count0), 32'h0);
    check_eq("wrap_lclk_both",    32'(lc0),    32'h3);
    check_eq("stop_hold_final",   32'(count1), 32'h0203);
    check_eq("stop_done_set",     32'(done1),  32'h1);
    repeat (3) cycle(1'b0, 1'b1, 16'h0);
    check_eq("stop_frozen",       32'(count1), 32'h0203);
    check_eq("stop_no_lclk",      32'(lc1),    32'h0);
    cycle(1'b1, 1'b0, {8'd4, 8'd0});
    check_eq("load_clears_done",  32'(done1),  32'h0);
    check_eq("load_clears_count", 32'(count1), 32'h0);

    // Single-element inner level.
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b0, 1'b1, 16'h0);
      check_eq("lvl0_stays_zero", 32'(count0[7:0]), 32'h0);
      check_eq("lvl0_last_high",  32'(last0[0]),    32'h1);
      if (k == 4) check_eq("lvl1_at_max", 32'(count0), 32'h0400);
    end
    check_eq("lvl1_wrapped", 32'(count0), 32'h0);

    // load wins over a simultaneous en.
    cycle(1'b1, 1'b0, {8'd2, 8'd3});
    repeat (6) cycle(1'b0, 1'b1, 16'h0);
    check_eq("pre_load_pos", 32'(count0), 32'h0102);
    cycle(1'b1, 1'b1, {8'd1, 8'd1});
    check_eq("load_over_en", 32'(count0), 32'h0);
    cycle(1'b0, 1'b1, 16'h0);
    check_eq("new_max_active", 32'(count0), 32'h0001);
    check_eq("new_max_last",   32'(last0),  32'h1);

    // Short asynchronous reset pulse between edges.
    cycle(1'b1, 1'b0, {8'd2, 8'd3});
    repeat (4) cycle(1'b0, 1'b1, 16'h0);
    en = 1'b0;
    check_eq("pre_reset_lclk", 32'(lc0), 32'h1);
    #1 reset = 1'b1;
    #1;
    model_reset();
    check_eq("async_count", 32'(count0), 32'h0);
    check_eq("async_lclk",  32'(lc0),    32'h0);
    check_all();
    #2 reset = 1'b0;

    for (int k = 0; k < 2000; k++) begin
      cycle($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20,
            {8'($urandom_range(0, 20)), 8'($urandom_range(0, 20))});
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
